// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Optional feature macro: MCU_JUMP_EN (adds the JUMP state and decodes opcode 000010).
package mcu_pkg;

    localparam int unsigned OPC_W      = 6;
    localparam int unsigned FN_W       = 6;
    localparam int unsigned ALU_CODE_W = 4;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC_R = 4'd7,
        S_ALUWB  = 4'd8,
        S_EXEC_I = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11
`ifdef MCU_JUMP_EN
        , S_JUMP = 4'd12
`endif
    } state_t;

    // Which source drives the ALU operation in the current state
    typedef enum logic [1:0] {
        ALU_CLS_ADD   = 2'd0,
        ALU_CLS_SUB   = 2'd1,
        ALU_CLS_FUNCT = 2'd2,
        ALU_CLS_IMM   = 2'd3
    } alu_class_t;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0100;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0101;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu_decoder.sv
// Maps state class, latched opcode and Funct to an ALU control code; flags unknown Funct.
module alu_decoder
    import mcu_pkg::*;
#(
    parameter int unsigned OP_WIDTH       = 6,
    parameter int unsigned FUNCT_WIDTH    = 6,
    parameter int unsigned ALU_CTRL_WIDTH = 4
) (
    input  alu_class_t                alu_class,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [FUNCT_WIDTH-1:0]    funct,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control_c,
    output logic                      funct_illegal_c
);

    logic [ALU_CODE_W-1:0] code;

    // Select the ALU code for the active class
    always_comb begin
        code            = ALU_ADD;
        funct_illegal_c = 1'b0;
        case (alu_class)
            ALU_CLS_ADD: code = ALU_ADD;
            ALU_CLS_SUB: code = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct)
                    FUNCT_WIDTH'(FN_ADD): code = ALU_ADD;
                    FUNCT_WIDTH'(FN_SUB): code = ALU_SUB;
                    FUNCT_WIDTH'(FN_AND): code = ALU_AND;
                    FUNCT_WIDTH'(FN_OR):  code = ALU_OR;
                    FUNCT_WIDTH'(FN_NOR): code = ALU_NOR;
                    FUNCT_WIDTH'(FN_SLT): code = ALU_SLT;
                    default:              funct_illegal_c = 1'b1;
                endcase
            end
            ALU_CLS_IMM: begin
                case (op)
                    OP_WIDTH'(OPC_ADDI): code = ALU_ADD;
                    OP_WIDTH'(OPC_SLTI): code = ALU_SLT;
                    OP_WIDTH'(OPC_ANDI): code = ALU_AND;
                    OP_WIDTH'(OPC_ORI):  code = ALU_OR;
                    default:             code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control_c = ALU_CTRL_WIDTH'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath.
// Optional feature macro: MCU_JUMP_EN (JUMP state; opcode 000010 is illegal without it).
// Strobes decode from the state register, gated only by Zero and MemReady, so
// FETCH/MEMRD/MEMWR can react to MemReady in the same cycle.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned OP_WIDTH       = 6,
    parameter int unsigned FUNCT_WIDTH    = 6,
    parameter int unsigned ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [OP_WIDTH-1:0]       OP,
    input  logic [FUNCT_WIDTH-1:0]    Funct,
    input  logic                      Zero,
    input  logic                      MemReady,
    output logic                      PCWrite,
    output logic                      IorD,
    output logic                      MemWrite,
    output logic                      IRWrite,
    output logic                      RegDst,
    output logic                      MemtoReg,
    output logic                      RegWrite,
    output logic                      ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic [1:0]                PCSrc,
    output logic                      Illegal_o
);

    state_t                    state;
    state_t                    state_nxt;
    logic [OP_WIDTH-1:0]       op_q;
    alu_class_t                alu_class;
    logic [ALU_CTRL_WIDTH-1:0] alu_control_c;
    logic                      funct_illegal_c;

    alu_decoder #(
        .OP_WIDTH       (OP_WIDTH),
        .FUNCT_WIDTH    (FUNCT_WIDTH),
        .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
    ) u_alu_decoder (
        .alu_class       (alu_class),
        .op              (op_q),
        .funct           (Funct),
        .alu_control_c   (alu_control_c),
        .funct_illegal_c (funct_illegal_c)
    );

    // State register; opcode is captured in DECODE so later states never re-read OP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= OP;
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt  = state;
        alu_class  = ALU_CLS_ADD;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = '0;
        PCSrc      = 2'b00;
        Illegal_o  = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_control_c;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                if (MemReady) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = alu_control_c;
                case (OP)
                    OP_WIDTH'(OPC_LW),
                    OP_WIDTH'(OPC_SW):    state_nxt = S_MEMADR;
                    OP_WIDTH'(OPC_RTYPE): state_nxt = S_EXEC_R;
                    OP_WIDTH'(OPC_ADDI),
                    OP_WIDTH'(OPC_SLTI),
                    OP_WIDTH'(OPC_ANDI),
                    OP_WIDTH'(OPC_ORI):   state_nxt = S_EXEC_I;
                    OP_WIDTH'(OPC_BEQ),
                    OP_WIDTH'(OPC_BNE):   state_nxt = S_BRANCH;
`ifdef MCU_JUMP_EN
                    OP_WIDTH'(OPC_J):     state_nxt = S_JUMP;
`endif
                    default: begin
                        Illegal_o = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = alu_control_c;
                state_nxt  = (op_q == OP_WIDTH'(OPC_SW)) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (MemReady) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) state_nxt = S_FETCH;
            end
            S_EXEC_R: begin
                alu_class  = ALU_CLS_FUNCT;
                ALUSrcA    = 1'b1;
                ALUControl = alu_control_c;
                if (funct_illegal_c) begin
                    Illegal_o = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_ALUWB;
                end
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_EXEC_I: begin
                alu_class  = ALU_CLS_IMM;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = alu_control_c;
                state_nxt  = S_IWB;
            end
            S_IWB: begin
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_class  = ALU_CLS_SUB;
                ALUSrcA    = 1'b1;
                ALUControl = alu_control_c;
                PCSrc      = 2'b01;
                PCWrite    = (op_q == OP_WIDTH'(OPC_BNE)) ? !Zero : Zero;
                state_nxt  = S_FETCH;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                PCSrc     = 2'b10;
                PCWrite   = 1'b1;
                state_nxt = S_FETCH;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected control vectors.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [1:0] PCSrc;
    logic       Illegal_o;

    int total = 0;
    int bad   = 0;

    multicycle_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .OP         (OP),
        .Funct      (Funct),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .Illegal_o  (Illegal_o)
    );

    always #5 clk = ~clk;

    // {PCWrite,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,Illegal_o}
    logic [16:0] outs;
    assign outs = {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUControl, PCSrc, Illegal_o};

    function automatic logic [16:0] ctl(input logic pcw, input logic iord, input logic mw,
                                        input logic irw, input logic rd, input logic m2r,
                                        input logic rw, input logic asa, input logic [1:0] asb,
                                        input logic [3:0] alu, input logic [1:0] pcs,
                                        input logic ill);
        return {pcw, iord, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, ill};
    endfunction

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare at the falling edge, then advance to just after the next rising edge
    task automatic ex(input string tag, input logic [16:0] exp);
        @(negedge clk);
        chk(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    logic [16:0] V_ZERO, V_FETCH, V_FWAIT, V_DEC, V_DEC_ILL, V_MEMADR, V_MEMRD, V_MEMWB;
    logic [16:0] V_MEMWR, V_EXEC_SUB, V_ALUWB, V_EXEC_ORI, V_EXEC_SLTI, V_IWB;
    logic [16:0] V_BR_T, V_BR_N, V_JUMP;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        V_ZERO      = '0;
        V_FETCH     = ctl(1,0,0,1,0,0,0,0,2'b01,4'b0100,2'b00,0);
        V_FWAIT     = ctl(0,0,0,0,0,0,0,0,2'b01,4'b0100,2'b00,0);
        V_DEC       = ctl(0,0,0,0,0,0,0,0,2'b11,4'b0100,2'b00,0);
        V_DEC_ILL   = ctl(0,0,0,0,0,0,0,0,2'b11,4'b0100,2'b00,1);
        V_MEMADR    = ctl(0,0,0,0,0,0,0,1,2'b10,4'b0100,2'b00,0);
        V_MEMRD     = ctl(0,1,0,0,0,0,0,0,2'b00,4'b0000,2'b00,0);
        V_MEMWB     = ctl(0,0,0,0,0,1,1,0,2'b00,4'b0000,2'b00,0);
        V_MEMWR     = ctl(0,1,1,0,0,0,0,0,2'b00,4'b0000,2'b00,0);
        V_EXEC_SUB  = ctl(0,0,0,0,0,0,0,1,2'b00,4'b0101,2'b00,0);
        V_ALUWB     = ctl(0,0,0,0,1,0,1,0,2'b00,4'b0000,2'b00,0);
        V_EXEC_ORI  = ctl(0,0,0,0,0,0,0,1,2'b10,4'b0001,2'b00,0);
        V_EXEC_SLTI = ctl(0,0,0,0,0,0,0,1,2'b10,4'b0111,2'b00,0);
        V_IWB       = ctl(0,0,0,0,0,0,1,0,2'b00,4'b0000,2'b00,0);
        V_BR_T      = ctl(1,0,0,0,0,0,0,1,2'b00,4'b0101,2'b01,0);
        V_BR_N      = ctl(0,0,0,0,0,0,0,1,2'b00,4'b0101,2'b01,0);
        V_JUMP      = ctl(1,0,0,0,0,0,0,0,2'b00,4'b0000,2'b10,0);

        reset = 1'b0; OP = 6'b000000; Funct = 6'b100000; Zero = 1'b0; MemReady = 1'b1;

        // Reset held, then released: IDLE one cycle, then FETCH
        @(negedge clk);
        @(negedge clk);
        chk("rst_outs", outs, V_ZERO);
        @(posedge clk); #1;
        reset = 1'b1;
        ex("idle", V_ZERO);

        // R-type SUB: 4 cycles
        OP = 6'b000000; Funct = 6'b100010;
        ex("r_fetch", V_FETCH);
        ex("r_decode", V_DEC);
        ex("r_exec", V_EXEC_SUB);
        ex("r_aluwb", V_ALUWB);

        // lw with MemReady low for 3 MEMRD cycles: 8 cycles
        OP = 6'b100011;
        ex("lw_fetch", V_FETCH);
        ex("lw_decode", V_DEC);
        ex("lw_memadr", V_MEMADR);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) ex("lw_memrd_wait", V_MEMRD);
        MemReady = 1'b1;
        ex("lw_memrd_done", V_MEMRD);
        ex("lw_memwb", V_MEMWB);

        // sw with one FETCH stall and one MEMWR stall
        OP = 6'b101011;
        MemReady = 1'b0;
        ex("sw_fetch_wait", V_FWAIT);
        MemReady = 1'b1;
        ex("sw_fetch", V_FETCH);
        ex("sw_decode", V_DEC);
        ex("sw_memadr", V_MEMADR);
        MemReady = 1'b0;
        ex("sw_memwr_wait", V_MEMWR);
        MemReady = 1'b1;
        ex("sw_memwr_done", V_MEMWR);

        // Branches
        OP = 6'b000100; Zero = 1'b1;
        ex("beq_fetch", V_FETCH);
        ex("beq_decode", V_DEC);
        ex("beq_z1", V_BR_T);
        OP = 6'b000101; Zero = 1'b1;
        ex("bne_fetch", V_FETCH);
        ex("bne_decode", V_DEC);
        ex("bne_z1", V_BR_N);
        OP = 6'b000101; Zero = 1'b0;
        ex("bne0_fetch", V_FETCH);
        ex("bne0_decode", V_DEC);
        ex("bne_z0", V_BR_T);
        OP = 6'b000100; Zero = 1'b0;
        ex("beq0_fetch", V_FETCH);
        ex("beq0_decode", V_DEC);
        ex("beq_z0", V_BR_N);

        // I-type ops
        OP = 6'b001101;
        ex("ori_fetch", V_FETCH);
        ex("ori_decode", V_DEC);
        ex("ori_exec", V_EXEC_ORI);
        ex("ori_iwb", V_IWB);
        OP = 6'b001010;
        ex("slti_fetch", V_FETCH);
        ex("slti_decode", V_DEC);
        ex("slti_exec", V_EXEC_SLTI);
        ex("slti_iwb", V_IWB);

        // Illegal opcode: 2 cycles, single Illegal_o pulse
        OP = 6'b111111;
        ex("ill_fetch", V_FETCH);
        ex("ill_decode", V_DEC_ILL);

        // Illegal Funct: flagged in EXEC_R, no write, back to FETCH
        OP = 6'b000000; Funct = 6'b111111;
        ex("rill_fetch", V_FETCH);
        ex("rill_decode", V_DEC);
        @(negedge clk);
        chk("rill_illegal", 17'(Illegal_o), 17'd1);
        chk("rill_regwrite", 17'(RegWrite), 17'd0);
        @(posedge clk); #1;

        // Jump opcode
        OP = 6'b000010; Funct = 6'b100000;
        ex("j_fetch", V_FETCH);
`ifdef MCU_JUMP_EN
        ex("j_decode", V_DEC);
        ex("j_jump", V_JUMP);
`else
        ex("j_decode_ill", V_DEC_ILL);
`endif

        // Asynchronous reset in the middle of a stalled sw
        OP = 6'b101011;
        ex("rsw_fetch", V_FETCH);
        ex("rsw_decode", V_DEC);
        ex("rsw_memadr", V_MEMADR);
        MemReady = 1'b0;
        ex("rsw_memwr", V_MEMWR);
        #2;
        reset = 1'b0;
        #1;
        chk("rsw_async", outs, V_ZERO);
        @(negedge clk);
        chk("rsw_held", outs, V_ZERO);
        @(posedge clk); #1;
        reset = 1'b1; MemReady = 1'b1;
        ex("rsw_idle", V_ZERO);
        ex("rsw_fetch_again", V_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style finite state machine that generates every datapath control strobe for the multicycle MIPS `Data_Path`. It replaces hand-sequenced control with a decoded instruction flow: fetch, decode, execute, memory and write-back. It sits beside `Data_Path`, consumes `OP`/`Funct`/`Zero` and drives the control bus. It adds I-type ALU ops, `bne`, a memory-ready handshake and illegal-instruction flagging.

## Interface
- `OP_WIDTH`, 6, opcode field width
- `FUNCT_WIDTH`, 6, function field width
- `ALU_CTRL_WIDTH`, 4, ALUControl width (≥3)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `OP`  in  OP_WIDTH  instruction opcode (valid from DECODE onward)
- `Funct`  in  FUNCT_WIDTH  R-type function field
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory access completes this cycle
- `PCWrite`  out  1  PC load enable (includes taken-branch term)
- `IorD`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA`  out  1 each  datapath strobes
- `ALUSrcB`  out  2  00 reg B, 01 const 4, 10 imm, 11 imm<<2
- `ALUControl`  out  ALU_CTRL_WIDTH  ALU op
- `PCSrc`  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- `Illegal_o`  out  1  one-cycle pulse on unsupported opcode/funct

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, EXEC_I, IWB, BRANCH, JUMP.
- IDLE (reset): all outputs 0; next FETCH.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00. IRWrite=PCWrite=MemReady. Stay while MemReady=0; else DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target to ALUOut). Dispatch on OP:
  - lw/sw (100011/101011): MEMADR
  - R (000000): EXEC_R
  - addi/slti/andi/ori (001000/001010/001100/001101): EXEC_I
  - beq/bne (000100/000101): BRANCH
  - j (000010): JUMP
  - otherwise: Illegal_o=1, next FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw→MEMRD, sw→MEMWR.
- MEMRD: IorD=1; hold until MemReady, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
- MEMWR: IorD=1, MemWrite=1; hold until MemReady, then FETCH. MemWrite stays high while holding.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct.
  - Funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
  - Unknown Funct: Illegal_o=1, next FETCH, no write.
  - Known Funct: next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, op per opcode (ADD/SLT/AND/OR); next IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01.
  - beq: PCWrite=Zero.
  - bne: PCWrite=!Zero.
- JUMP: PCSrc=10, PCWrite=1.
- ALU codes: AND 0000, OR 0001, NOR 0010, ADD 0100, SUB 0101, SLT 0111, zero-extended to ALU_CTRL_WIDTH.
- Outputs not listed for a state are 0.

## Timing
- Reset assertion forces IDLE asynchronously, even mid-instruction; all outputs 0 while reset is low. First FETCH is one cycle after deassertion.
- Outputs decode combinationally from the state register, plus Zero and MemReady gating only.
- Cycle counts with MemReady=1:
  - lw 5
  - R-type, I-type, sw 4
  - beq/bne, j 3
  - illegal 2
- Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle. No write enable fires twice per instruction.
- OP/Funct are sampled only in DECODE/EXEC_R and must be stable there.

## Configuration
- `MCU_JUMP_EN` defined: JUMP state is present; opcode 000010 executes.
- `MCU_JUMP_EN` undefined: JUMP state is removed; 000010 is treated as illegal (Illegal_o pulse, back to FETCH). PCSrc never equals 10.

## Structure
- Package `mcu_pkg`: state enum, opcode/funct localparams, ALU code localparams.
- Sub-module `alu_decoder` (Funct/OP/state class → ALUControl, funct-illegal flag).
- The FSM is in the top module.

## Test plan
- Reset low mid-MEMWR, then release → outputs all 0 during reset; IDLE, then FETCH with IRWrite=1 next cycle.
- R-type Funct=100010, MemReady=1 → EXEC_R with ALUControl=0101; ALUWB with RegDst=1, RegWrite=1; 4 cycles total.
- lw with MemReady low 3 cycles in MEMRD → IorD=1 held 4 cycles; MemtoReg=1, RegWrite=1 once; 8 cycles total.
- beq Zero=1 vs bne Zero=1 → PCWrite=1 with PCSrc=01 for beq; PCWrite=0 for bne.
- OP=111111 → Illegal_o high exactly 1 cycle in DECODE; no RegWrite/MemWrite; back to FETCH.
- OP=000010 → with `MCU_JUMP_EN`: PCSrc=10, PCWrite=1, 3 cycles. Without it: Illegal_o pulse.
